// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Job handshake and operand/result bus between an add-job requester and the
// bit-serial adder controller.
//
// Signals:
//   start  requester -> ctrl  job request, sampled only while idle
//   abort  requester -> ctrl  cancel a running job
//   a, b   requester -> ctrl  WIDTH-bit operands, captured on accepted start
//   cin    requester -> ctrl  carry-in, captured on accepted start
//   busy   ctrl -> requester  high while a job is running
//   done   ctrl -> requester  one-cycle pulse, result valid
//   sum    ctrl -> requester  registered WIDTH-bit result
//   cout   ctrl -> requester  registered carry-out, held with sum
//
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, abort, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, abort, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller. A single one-bit full-adder cell is stepped
// over WIDTH clock cycles, LSB first, to produce {cout, sum} = a + b + cin.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_add_ctrl_if.slave (start/abort/a/b/cin in,
//          busy/done/sum/cout out)
//
// Timing: start accepted at edge E0 -> busy between E0 and E(WIDTH),
// sum/cout updated at E(WIDTH), done high for the following cycle.
// Back-to-back jobs can issue every WIDTH+2 cycles.
// ---------------------------------------------------------------------------

// One-bit full-adder cell (shared datapath element).
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    // Holds the WIDTH-1 sum bits produced before the current one; the
    // current bit from the cell completes the word on the final edge.
    logic [WIDTH-2:0] s_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] s_cat;
    logic [WIDTH-2:0] s_sh_d;

    fulladder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the MSB; on the last edge this is the whole result.
    assign s_cat  = {fa_s, s_sh_q};
    assign s_sh_d = s_cat[WIDTH-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // abort is meaningless here, so start alone decides.
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // abort takes priority even on the final bit, so a
                    // cancelled job never touches sum/cout.
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        s_sh_q  <= s_sh_d;
                        carry_q <= fa_co;
                        a_sh_q  <= a_sh_q >> 1;
                        b_sh_q  <= b_sh_q >> 1;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            sum_q   <= s_cat;
                            cout_q  <= fa_co;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register: no combinational input path.
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       abort;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    int n_checks;
    int n_pass;
    int done_cnt;
    logic [4:0] sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and retire any result the DUT presents.
    task automatic step();
        logic [4:0] exp;
        @(negedge clk);
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp = sb.pop_front();
                check("result", int'({bus.cout, bus.sum}), int'(exp));
                $display("job done: {cout,sum}=%b expected %b", {bus.cout, bus.sum}, exp);
            end
        end
    endtask

    // Issue one job from IDLE and wait (bounded) for its done pulse.
    task automatic run_job(input logic [3:0] ta, input logic [3:0] tb_v,
                           input logic tc, input logic tab, input logic [4:0] exp);
        int  lat;
        int  nbusy;
        bit  seen;
        sb.push_back(exp);
        bus.a     = ta;
        bus.b     = tb_v;
        bus.cin   = tc;
        bus.start = 1'b1;
        bus.abort = tab;
        lat   = 0;
        nbusy = 0;
        seen  = 1'b0;
        while (!seen && lat < 20) begin
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            lat++;
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        check("latency", lat, W + 1);
        check("busy_cycles", nbusy, W);
        step();  // DONE -> IDLE
    endtask

    vec_t vecs[6];
    int   base_cnt;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        done_cnt = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        vecs[0] = '{4'b0101, 4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0};
        vecs[1] = '{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1};
        vecs[2] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1};
        vecs[3] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[4] = '{4'b1010, 4'b0101, 1'b1, 1'b1, 4'b0000, 1'b1};  // start+abort in IDLE
        vecs[5] = '{4'b0111, 4'b1000, 1'b0, 1'b0, 4'b1111, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_sum",  int'(bus.sum),  0);
        check("rst_cout", int'(bus.cout), 0);
        rst_n = 1'b1;
        step();

        // Table-driven jobs
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].abort,
                    {vecs[i].exp_cout, vecs[i].exp_sum});
        end
        check("done_count_table", done_cnt, 6);

        // start during RUN ignored, operand change after capture ignored
        base_cnt = done_cnt;
        sb.push_back(5'b00100);
        bus.a = 4'b0010; bus.b = 4'b0010; bus.cin = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.a = 4'b1111; bus.b = 4'b1111; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (12) step();
        check("ignored_start_busy", int'(bus.busy), 0);
        check("ignored_start_dones", done_cnt - base_cnt, 1);
        $display("ignored-start seq: sum=%b cout=%b", bus.sum, bus.cout);

        // abort in RUN cycle 2: no done, result held
        base_cnt = done_cnt;
        bus.a = 4'b0110; bus.b = 4'b0101; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("abort_pre_busy", int'(bus.busy), 1);
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy_drop", int'(bus.busy), 0);
        repeat (6) step();
        check("abort_sum_held", int'({bus.cout, bus.sum}), 5'b00100);
        check("abort_no_done", done_cnt - base_cnt, 0);
        $display("abort seq: sum=%b cout=%b", bus.sum, bus.cout);
        run_job(4'b0001, 4'b0001, 1'b0, 1'b0, 5'b00010);

        // abort on the final RUN edge: result not committed
        base_cnt = done_cnt;
        bus.a = 4'b1111; bus.b = 4'b1111; bus.cin = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        check("last_abort_pre_busy", int'(bus.busy), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("last_abort_busy", int'(bus.busy), 0);
        check("last_abort_done", int'(bus.done), 0);
        repeat (3) step();
        check("last_abort_sum_held", int'({bus.cout, bus.sum}), 5'b00010);
        check("last_abort_no_done", done_cnt - base_cnt, 0);
        $display("final-edge abort seq: sum=%b cout=%b", bus.sum, bus.cout);

        // Asynchronous reset mid-RUN
        bus.a = 4'b1111; bus.b = 4'b0001; bus.cin = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_sum",  int'(bus.sum),  0);
        check("arst_cout", int'(bus.cout), 0);
        $display("async reset mid-run: busy=%b sum=%b cout=%b", bus.busy, bus.sum, bus.cout);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_job(4'b0111, 4'b0001, 1'b0, 1'b0, 5'b01000);

        // Exhaustive sweep against a + b + cin
        base_cnt = done_cnt;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_job(4'(ia), 4'(ib), 1'(ic), 1'b0, 5'(ia + ib + ic));
                end
            end
        end
        check("exhaustive_done_count", done_cnt - base_cnt, 512);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
